// File: rtl/uart_reg_responder_if.sv
// Bundle of uart byte-handshake and external register bus signals shared
// between uart_reg_responder (master) and its environment (slave).
interface uart_reg_responder_if;
    // uart receive side
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       recv_ack;
    // uart transmit side
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;
    // register bus
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;

    modport master (
        input  received, rx_byte, recv_error, is_transmitting, reg_rdata,
        output recv_ack, transmit, tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport slave (
        output received, rx_byte, recv_error, is_transmitting, reg_rdata,
        input  recv_ack, transmit, tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd
    );
endinterface

// File: rtl/uart_reg_responder.sv
// Host-side register peek/poke responder: parses request frames from the uart,
// performs one register read or write and returns a fixed 4-byte response.
module uart_reg_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_REQ       = 8'h55,
    parameter logic [7:0]  SYNC_RSP       = 8'hAA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_reg_responder_if.master  bus,
    output logic                  busy,
    output logic                  frame_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_RDWAIT,
        S_TX_START,
        S_TX_BUSY,
        S_TX_DONE
    } state_t;

    localparam int unsigned   CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_RD     = 8'h01;
    localparam logic [7:0] CMD_WR     = 8'h02;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_CHK = 8'h01;
    localparam logic [7:0] ST_BAD_CMD = 8'h02;

    state_t        state_q;
    logic [CW-1:0] to_cnt_q;
    logic [7:0]    cmd_q;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    status_q;
    logic [7:0]    rdata_q;
    logic [1:0]    idx_q;
    logic          rd_phase_q;
    logic          recv_ack_q;
    logic          ack_d1_q;
    logic          transmit_q;
    logic [7:0]    tx_byte_q;
    logic          reg_wr_q;
    logic          reg_rd_q;
    logic [7:0]    reg_addr_q;
    logic [7:0]    reg_wdata_q;
    logic          frame_err_q;

    logic          rx_ok;
    logic          err_evt;
    logic          rx_take;
    logic [7:0]    chk_exp;
    logic [7:0]    rsp_byte;

    // Receive qualification, expected checksum and current response byte
    always_comb begin
        // The uart flags are still set during the ack pulse and one cycle after
        // it, so both of those cycles are masked.
        rx_ok    = !recv_ack_q && !ack_d1_q;
        err_evt  = rx_ok && bus.recv_error;
        rx_take  = rx_ok && bus.received && !bus.recv_error;
        chk_exp  = (cmd_q == CMD_WR) ? (cmd_q ^ addr_q ^ data_q) : (cmd_q ^ addr_q);
        case (idx_q)
            2'd0:    rsp_byte = SYNC_RSP;
            2'd1:    rsp_byte = status_q;
            2'd2:    rsp_byte = rdata_q;
            default: rsp_byte = status_q ^ rdata_q;
        endcase
    end

    // Frame parser, bus access and response sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            status_q    <= '0;
            rdata_q     <= '0;
            idx_q       <= '0;
            rd_phase_q  <= 1'b0;
            recv_ack_q  <= 1'b0;
            ack_d1_q    <= 1'b0;
            transmit_q  <= 1'b0;
            tx_byte_q   <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            recv_ack_q  <= 1'b0;
            ack_d1_q    <= recv_ack_q;
            transmit_q  <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            frame_err_q <= 1'b0;

            if (err_evt || rx_take) begin
                recv_ack_q <= 1'b1;
            end
            if (err_evt) begin
                frame_err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    to_cnt_q <= '0;
                    if (rx_take) begin
                        if (bus.rx_byte == SYNC_REQ) begin
                            state_q  <= S_CMD;
                            status_q <= ST_OK;
                            rdata_q  <= '0;
                            data_q   <= '0;
                            idx_q    <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end

                S_CMD, S_ADDR, S_DATA, S_CHK: begin
                    if (err_evt) begin
                        state_q <= S_IDLE;
                    end else if (rx_take) begin
                        to_cnt_q <= '0;
                        if (state_q == S_CMD) begin
                            cmd_q   <= bus.rx_byte;
                            state_q <= S_ADDR;
                            if (bus.rx_byte != CMD_RD && bus.rx_byte != CMD_WR) begin
                                status_q <= ST_BAD_CMD;
                            end
                        end else if (state_q == S_ADDR) begin
                            addr_q  <= bus.rx_byte;
                            state_q <= (cmd_q == CMD_WR) ? S_DATA : S_CHK;
                        end else if (state_q == S_DATA) begin
                            data_q  <= bus.rx_byte;
                            state_q <= S_CHK;
                        end else begin
                            if (bus.rx_byte != chk_exp) begin
                                status_q <= ST_BAD_CHK;
                                state_q  <= S_TX_START;
                            end else if (status_q != ST_OK) begin
                                state_q <= S_TX_START;
                            end else if (cmd_q == CMD_WR) begin
                                reg_wr_q    <= 1'b1;
                                reg_addr_q  <= addr_q;
                                reg_wdata_q <= data_q;
                                state_q     <= S_TX_START;
                            end else begin
                                reg_rd_q   <= 1'b1;
                                reg_addr_q <= addr_q;
                                state_q    <= S_RDWAIT;
                            end
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                S_RDWAIT: begin
                    // The strobe is registered, so read data appears one cycle
                    // after the strobe cycle; rd_phase_q marks that second cycle.
                    if (err_evt) begin
                        rd_phase_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (rd_phase_q) begin
                        rd_phase_q <= 1'b0;
                        rdata_q    <= bus.reg_rdata;
                        state_q    <= S_TX_START;
                    end else begin
                        rd_phase_q <= 1'b1;
                    end
                end

                S_TX_START: begin
                    if (!bus.is_transmitting) begin
                        transmit_q <= 1'b1;
                        tx_byte_q  <= rsp_byte;
                        state_q    <= S_TX_BUSY;
                    end
                end

                S_TX_BUSY: begin
                    if (bus.is_transmitting) begin
                        state_q <= S_TX_DONE;
                    end
                end

                S_TX_DONE: begin
                    if (!bus.is_transmitting) begin
                        if (idx_q == 2'd3) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= S_TX_START;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.recv_ack  = recv_ack_q;
    assign bus.transmit  = transmit_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign frame_err     = frame_err_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: uart byte source, uart transmitter
// model and a register file model around the responder.
module tb_uart_reg_responder;

    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic frame_err;

    uart_reg_responder_if bus();

    uart_reg_responder #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_REQ      (8'h55),
        .SYNC_RSP      (8'hAA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned rd_cnt = 0, wr_cnt = 0, ferr_cnt = 0;
    logic [7:0]  rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic [7:0]  tx_log[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  rdval = 8'h3C;
    int unsigned rd0, wr0, f0, txb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe and frame_err monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.reg_rd) begin
                rd_cnt++;
                rd_addr = bus.reg_addr;
            end
            if (bus.reg_wr) begin
                wr_cnt++;
                wr_addr = bus.reg_addr;
                wr_data = bus.reg_wdata;
            end
            if (frame_err) ferr_cnt++;
        end
    end

    // Register file: read data valid only in the cycle after the strobe
    initial begin
        bus.reg_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            if (bus.reg_rd) begin
                @(posedge clk);
                #1 bus.reg_rdata = rdval;
                @(posedge clk);
                #1 bus.reg_rdata = 8'hEE;
            end
        end
    end

    // uart transmitter: logs each byte, busy for a few cycles
    initial begin
        bus.is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.transmit) begin
                tx_log.push_back(bus.tx_byte);
                @(posedge clk);
                #1 bus.is_transmitting = 1'b1;
                repeat (3) @(posedge clk);
                #1 bus.is_transmitting = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic err);
        logic got;
        @(posedge clk);
        #1;
        bus.rx_byte    = b;
        bus.received   = !err;
        bus.recv_error = err;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.recv_ack) got = 1'b1;
        end
        if (!got) check("ack_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.received   = 1'b0;
        bus.recv_error = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
    endtask

    task automatic mark();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        f0  = ferr_cnt;
        txb = tx_log.size();
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] st, input logic [7:0] d);
        logic [7:0] exp[4];
        exp[0] = 8'hAA;
        exp[1] = st;
        exp[2] = d;
        exp[3] = st ^ d;
        check({tag, "_txcnt"}, 32'(tx_log.size() - txb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_tx%0d", tag, i),
                  (txb + i < tx_log.size()) ? 32'(tx_log[txb + i]) : 32'hFFFF, 32'(exp[i]));
        end
    endtask

    initial begin
        logic seen;
        bus.received   = 1'b0;
        bus.rx_byte    = '0;
        bus.recv_error = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ack", 32'(bus.recv_ack), 32'd0);
        check("rst_transmit", 32'(bus.transmit), 32'd0);
        check("rst_txbyte", 32'(bus.tx_byte), 32'd0);
        check("rst_wr", 32'(bus.reg_wr), 32'd0);
        check("rst_rd", 32'(bus.reg_rd), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Read: 55 01 10 11 with reg 3C
        mark();
        frame_q = {8'h55, 8'h01, 8'h10, 8'h11};
        send_frame();
        wait_idle();
        check("rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        check("rd_addr", 32'(rd_addr), 32'h10);
        check("rd_nowr", 32'(wr_cnt - wr0), 32'd0);
        check("rd_ferr", 32'(ferr_cnt - f0), 32'd0);
        expect_rsp("rd", 8'h00, 8'h3C);

        // Write: 55 02 20 7E 5C
        mark();
        frame_q = {8'h55, 8'h02, 8'h20, 8'h7E, 8'h5C};
        send_frame();
        wait_idle();
        check("wr_strobes", 32'(wr_cnt - wr0), 32'd1);
        check("wr_addr", 32'(wr_addr), 32'h20);
        check("wr_data", 32'(wr_data), 32'h7E);
        check("wr_nord", 32'(rd_cnt - rd0), 32'd0);
        expect_rsp("wr", 8'h00, 8'h00);

        // Bad checksum
        mark();
        frame_q = {8'h55, 8'h01, 8'h10, 8'h00};
        send_frame();
        wait_idle();
        check("bchk_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        expect_rsp("bchk", 8'h01, 8'h00);

        // Bad command
        mark();
        frame_q = {8'h55, 8'h07, 8'h10, 8'h17};
        send_frame();
        wait_idle();
        check("bcmd_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        expect_rsp("bcmd", 8'h02, 8'h00);

        // Garbage byte then a normal read
        mark();
        rdval = 8'h5A;
        frame_q = {8'h12, 8'h55, 8'h01, 8'h10, 8'h11};
        send_frame();
        wait_idle();
        check("garb_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("garb_rd", 32'(rd_cnt - rd0), 32'd1);
        expect_rsp("garb", 8'h00, 8'h5A);

        // Timeout after 55 01
        mark();
        frame_q = {8'h55, 8'h01};
        send_frame();
        check("to_busy_mid", 32'(busy), 32'd1);
        repeat (TO + 10) @(posedge clk);
        #1;
        check("to_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_notx", 32'(tx_log.size() - txb), 32'd0);
        check("to_nostrobe", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

        // uart receive error mid-frame abandons it
        mark();
        frame_q = {8'h55, 8'h02, 8'h20};
        send_frame();
        send_byte(8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("rerr_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("rerr_busy", 32'(busy), 32'd0);
        check("rerr_nostrobe", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

        // Reset during the second response byte
        mark();
        rdval = 8'h3C;
        frame_q = {8'h55, 8'h01, 8'h10, 8'h11};
        send_frame();
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (tx_log.size() >= txb + 2) seen = 1'b1;
        end
        check("mrst_reach", 32'(seen), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_transmit", 32'(bus.transmit), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_strobes", 32'({bus.reg_rd, bus.reg_wr}), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check("mrst_txcnt", 32'(tx_log.size() - txb), 32'd2);
        mark();
        send_frame();
        wait_idle();
        check("post_rd", 32'(rd_cnt - rd0), 32'd1);
        expect_rsp("post", 8'h00, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
